// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// datapath mux selects and the bundled control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_JUMP   = 4'd11
  } state_t;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       mdrwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_if.sv
// Controller <-> datapath bundle: IR opcode, ALU flag and memory handshake in,
// datapath control and debug observability out.
interface mips_ctrl_if #(parameter int CNT_W = 32);

  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_en;
  logic             iord;
  logic             memread;
  logic             memwrite;
  logic             irwrite;
  logic             mdrwrite;
  logic             memtoreg;
  logic             regdst;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       aluop;
  logic [1:0]       pcsource;
  logic [3:0]       state;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, iord, memread, memwrite, irwrite, mdrwrite, memtoreg,
           regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
           state, illegal_op, instr_count
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, iord, memread, memwrite, irwrite, mdrwrite, memtoreg,
           regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
           state, illegal_op, instr_count
  );

endinterface

// File: rtl/mips_ctrl_outdec.sv
// Moore output decode for the multi-cycle controller; zero and mem_ready only
// qualify the PC, IR and MDR load enables.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   zero,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  logic pcwrite;
  logic pcwritecond;

  always_comb begin
    ctrl        = '0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    case (state)
      ST_FETCH: begin
        ctrl.memread  = 1'b1;
        ctrl.alusrcb  = SRCB_FOUR;
        ctrl.irwrite  = mem_ready;
        pcwrite       = mem_ready;
      end
      ST_DECODE: ctrl.alusrcb = SRCB_SHIMM;
      ST_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      ST_MEMRD: begin
        ctrl.memread  = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.mdrwrite = mem_ready;
      end
      ST_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      // Write request is held for the whole wait; memory samples it as a level.
      ST_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alusrca  = 1'b1;
        ctrl.aluop    = ALUOP_SUB;
        ctrl.pcsource = PCSRC_ALUOUT;
        pcwritecond   = 1'b1;
      end
      ST_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      ST_ADDIWB: ctrl.regwrite = 1'b1;
      ST_JUMP: begin
        ctrl.pcsource = PCSRC_JUMP;
        pcwrite       = 1'b1;
      end
      default: ;
    endcase
    ctrl.pc_en = pcwrite | (pcwritecond & zero);
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with a shared memory port, retired-instruction
// counter and illegal-opcode pulse for debug.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic          clk,
  input logic          rst,
  mips_ctrl_if.master  bus
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_q;
  logic             illegal;
  logic             retire;
  ctrl_t            ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Retirement is flagged on the last cycle of each instruction path.
  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    retire  = 1'b0;
    case (state_q)
      ST_FETCH: if (bus.mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = ST_EXEC;
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JUMP;
          default: begin
            state_d = ST_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      ST_MEMADR: state_d = (bus.opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  if (bus.mem_ready) state_d = ST_MEMWB;
      ST_MEMWR: begin
        if (bus.mem_ready) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_MEMWB, ST_ALUWB, ST_ADDIWB, ST_BRANCH, ST_JUMP: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state     (state_q),
    .zero      (bus.zero),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  // Side-effecting enables are suppressed while reset is held so an abandoned
  // instruction cannot complete a write.
  assign bus.pc_en       = ctrl.pc_en    & ~rst;
  assign bus.irwrite     = ctrl.irwrite  & ~rst;
  assign bus.mdrwrite    = ctrl.mdrwrite & ~rst;
  assign bus.regwrite    = ctrl.regwrite & ~rst;
  assign bus.memwrite    = ctrl.memwrite & ~rst;
  assign bus.memread     = ctrl.memread  & ~rst;
  assign bus.illegal_op  = illegal       & ~rst;
  assign bus.iord        = ctrl.iord;
  assign bus.memtoreg    = ctrl.memtoreg;
  assign bus.regdst      = ctrl.regdst;
  assign bus.alusrca     = ctrl.alusrca;
  assign bus.alusrcb     = ctrl.alusrcb;
  assign bus.aluop       = ctrl.aluop;
  assign bus.pcsource    = ctrl.pcsource;
  assign bus.state       = state_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: an instruction-path model checked
// every cycle, plus hand-computed spot checks along the test sequence.
module tb_mips_multicycle_ctrl;

  localparam int P_FETCH  = 0;
  localparam int P_DECODE = 1;
  localparam int P_MEMADR = 2;
  localparam int P_MEMRD  = 3;
  localparam int P_MEMWB  = 4;
  localparam int P_MEMWR  = 5;
  localparam int P_EXEC   = 6;
  localparam int P_ALUWB  = 7;
  localparam int P_BRANCH = 8;
  localparam int P_ADDIEX = 9;
  localparam int P_ADDIWB = 10;
  localparam int P_JUMP   = 11;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_BAD   = 6'b111111;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mips_ctrl_if #(.CNT_W(32)) bus ();

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- instruction-path model ----------------
  int          phase;
  int          path[$];
  logic [31:0] mCount;
  bit          checkEn;

  function automatic bit knownOp(input logic [5:0] op);
    return op inside {OPC_RTYPE, OPC_LW, OPC_SW, OPC_BEQ, OPC_ADDI, OPC_J};
  endfunction

  task automatic loadRoute(input logic [5:0] op);
    path.delete();
    case (op)
      OPC_RTYPE: path = '{P_EXEC, P_ALUWB};
      OPC_LW:    path = '{P_MEMADR, P_MEMRD, P_MEMWB};
      OPC_SW:    path = '{P_MEMADR, P_MEMWR};
      OPC_BEQ:   path = '{P_BRANCH};
      OPC_ADDI:  path = '{P_ADDIEX, P_ADDIWB};
      OPC_J:     path = '{P_JUMP};
      default:   ;
    endcase
  endtask

  task automatic advance();
    if (path.size() == 0) begin
      phase = P_FETCH;
      mCount++;
    end else begin
      phase = path.pop_front();
    end
  endtask

  initial begin
    phase   = P_FETCH;
    mCount  = 0;
    checkEn = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      phase = P_FETCH;
      path.delete();
      mCount = 0;
      checkEn = 1;
    end else begin
      case (phase)
        P_FETCH: if (bus.mem_ready) phase = P_DECODE;
        P_DECODE: begin
          loadRoute(bus.opcode);
          if (path.size() == 0) phase = P_FETCH;
          else phase = path.pop_front();
        end
        P_MEMRD, P_MEMWR: if (bus.mem_ready) advance();
        default: advance();
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic       ePc, eIord, eRd, eWr, eIr, eMdr, eM2r, eDst, eRw, eA, eIll;
    logic [1:0] eB, eOp, eSrc;
    if (checkEn) begin
      {ePc, eIord, eRd, eWr, eIr, eMdr, eM2r, eDst, eRw, eA, eIll} = '0;
      {eB, eOp, eSrc} = '0;
      case (phase)
        P_FETCH:  begin eRd = 1; eB = 2'b01; eIr = bus.mem_ready; ePc = bus.mem_ready; end
        P_DECODE: begin eB = 2'b11; eIll = !knownOp(bus.opcode); end
        P_MEMADR: begin eA = 1; eB = 2'b10; end
        P_MEMRD:  begin eRd = 1; eIord = 1; eMdr = bus.mem_ready; end
        P_MEMWB:  begin eRw = 1; eM2r = 1; end
        P_MEMWR:  begin eWr = 1; eIord = 1; end
        P_EXEC:   begin eA = 1; eOp = 2'b10; end
        P_ALUWB:  begin eRw = 1; eDst = 1; end
        P_BRANCH: begin eA = 1; eOp = 2'b01; eSrc = 2'b01; ePc = bus.zero; end
        P_ADDIEX: begin eA = 1; eB = 2'b10; end
        P_ADDIWB: eRw = 1;
        P_JUMP:   begin ePc = 1; eSrc = 2'b10; end
        default:  ;
      endcase
      if (rst) {ePc, eIr, eMdr, eRw, eWr, eRd, eIll} = '0;
      checkOutput("state",       32'(bus.state),      32'(phase));
      checkOutput("instr_count", bus.instr_count,     mCount);
      checkOutput("pc_en",       32'(bus.pc_en),      32'(ePc));
      checkOutput("iord",        32'(bus.iord),       32'(eIord));
      checkOutput("memread",     32'(bus.memread),    32'(eRd));
      checkOutput("memwrite",    32'(bus.memwrite),   32'(eWr));
      checkOutput("irwrite",     32'(bus.irwrite),    32'(eIr));
      checkOutput("mdrwrite",    32'(bus.mdrwrite),   32'(eMdr));
      checkOutput("memtoreg",    32'(bus.memtoreg),   32'(eM2r));
      checkOutput("regdst",      32'(bus.regdst),     32'(eDst));
      checkOutput("regwrite",    32'(bus.regwrite),   32'(eRw));
      checkOutput("alusrca",     32'(bus.alusrca),    32'(eA));
      checkOutput("alusrcb",     32'(bus.alusrcb),    32'(eB));
      checkOutput("aluop",       32'(bus.aluop),      32'(eOp));
      checkOutput("pcsource",    32'(bus.pcsource),   32'(eSrc));
      checkOutput("illegal_op",  32'(bus.illegal_op), 32'(eIll));
    end
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input logic [5:0] op, input logic z, input logic mr, input logic r);
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = mr;
    rst           = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic [5:0] op, input logic z, input logic mr, input logic r);
    applyStimulus(op, z, mr, r);
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    applyStimulus(OPC_RTYPE, 0, 0, 1);
    tick();
    applyStimulus(OPC_RTYPE, 0, 0, 1);
    checkOutput("rst_memread_masked", 32'(bus.memread), 0);
    tick();
    checkOutput("rst_state", 32'(bus.state), 0);
    checkOutput("rst_count", bus.instr_count, 0);

    // R-type: FETCH, DECODE, EXEC, ALUWB
    applyStimulus(OPC_RTYPE, 0, 1, 0);
    checkOutput("release_memread", 32'(bus.memread), 1);
    tick();
    cycle(OPC_RTYPE, 0, 1, 0);
    applyStimulus(OPC_RTYPE, 0, 1, 0);
    checkOutput("rtype_exec_state", 32'(bus.state), 6);
    checkOutput("rtype_exec_regwrite", 32'(bus.regwrite), 0);
    tick();
    applyStimulus(OPC_RTYPE, 0, 1, 0);
    checkOutput("rtype_wb_regwrite", 32'(bus.regwrite), 1);
    checkOutput("rtype_wb_regdst", 32'(bus.regdst), 1);
    tick();
    checkOutput("rtype_count", bus.instr_count, 1);
    checkOutput("rtype_back_fetch", 32'(bus.state), 0);

    // LW with three memory wait cycles in MEMRD
    cycle(OPC_LW, 0, 1, 0);
    cycle(OPC_LW, 0, 1, 0);
    cycle(OPC_LW, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OPC_LW, 0, 0, 0);
      checkOutput("lw_wait_state", 32'(bus.state), 3);
      checkOutput("lw_wait_mdrwrite", 32'(bus.mdrwrite), 0);
      tick();
    end
    applyStimulus(OPC_LW, 0, 1, 0);
    checkOutput("lw_rd_mdrwrite", 32'(bus.mdrwrite), 1);
    tick();
    applyStimulus(OPC_LW, 0, 1, 0);
    checkOutput("lw_cycle7_memwb", 32'(bus.state), 4);
    checkOutput("lw_wb_memtoreg", 32'(bus.memtoreg), 1);
    tick();
    checkOutput("lw_cycle8_fetch", 32'(bus.state), 0);
    checkOutput("lw_count", bus.instr_count, 2);

    // BEQ taken, then not taken
    cycle(OPC_BEQ, 1, 1, 0);
    cycle(OPC_BEQ, 1, 1, 0);
    applyStimulus(OPC_BEQ, 1, 1, 0);
    checkOutput("beq_taken_pc_en", 32'(bus.pc_en), 1);
    tick();
    cycle(OPC_BEQ, 0, 1, 0);
    cycle(OPC_BEQ, 0, 1, 0);
    applyStimulus(OPC_BEQ, 0, 1, 0);
    checkOutput("beq_nottaken_pc_en", 32'(bus.pc_en), 0);
    tick();
    checkOutput("beq_count", bus.instr_count, 4);

    // SW then J
    cycle(OPC_SW, 0, 1, 0);
    applyStimulus(OPC_SW, 0, 1, 0);
    checkOutput("sw_decode_memwrite", 32'(bus.memwrite), 0);
    tick();
    cycle(OPC_SW, 0, 1, 0);
    applyStimulus(OPC_SW, 0, 1, 0);
    checkOutput("sw_memwrite", 32'(bus.memwrite), 1);
    tick();
    cycle(OPC_J, 0, 1, 0);
    cycle(OPC_J, 0, 1, 0);
    applyStimulus(OPC_J, 0, 1, 0);
    checkOutput("j_pcsource", 32'(bus.pcsource), 2);
    checkOutput("j_pc_en", 32'(bus.pc_en), 1);
    tick();
    checkOutput("sw_j_count", bus.instr_count, 6);

    // ADDI
    for (int i = 0; i < 4; i++) cycle(OPC_ADDI, 0, 1, 0);
    checkOutput("addi_count", bus.instr_count, 7);

    // Illegal opcode
    cycle(OPC_BAD, 0, 1, 0);
    applyStimulus(OPC_BAD, 0, 1, 0);
    checkOutput("illegal_pulse", 32'(bus.illegal_op), 1);
    tick();
    applyStimulus(OPC_BAD, 0, 0, 0);
    checkOutput("illegal_back_fetch", 32'(bus.state), 0);
    checkOutput("illegal_cleared", 32'(bus.illegal_op), 0);
    checkOutput("illegal_count", bus.instr_count, 7);
    checkOutput("fetch_wait_irwrite", 32'(bus.irwrite), 0);
    tick();

    // SW with memory wait in MEMWR
    cycle(OPC_SW, 0, 1, 0);
    cycle(OPC_SW, 0, 1, 0);
    cycle(OPC_SW, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(OPC_SW, 0, 0, 0);
      checkOutput("sw_wait_memwrite", 32'(bus.memwrite), 1);
      tick();
    end
    checkOutput("sw_wait_count", bus.instr_count, 7);
    cycle(OPC_SW, 0, 1, 0);
    checkOutput("sw_wait_done_count", bus.instr_count, 8);

    // Reset during a MEMRD wait
    cycle(OPC_LW, 0, 1, 0);
    cycle(OPC_LW, 0, 1, 0);
    cycle(OPC_LW, 0, 1, 0);
    cycle(OPC_LW, 0, 0, 0);
    applyStimulus(OPC_LW, 0, 1, 1);
    checkOutput("midrst_state", 32'(bus.state), 3);
    checkOutput("midrst_mdrwrite", 32'(bus.mdrwrite), 0);
    checkOutput("midrst_memread", 32'(bus.memread), 0);
    tick();
    applyStimulus(OPC_LW, 0, 1, 1);
    checkOutput("midrst_state0", 32'(bus.state), 0);
    checkOutput("midrst_count0", bus.instr_count, 0);
    tick();
    applyStimulus(OPC_LW, 0, 0, 0);
    checkOutput("midrst_release_memread", 32'(bus.memread), 1);
    checkOutput("midrst_release_irwrite", 32'(bus.irwrite), 0);
    tick();
    cycle(OPC_LW, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style FSM that sequences a multi-cycle variant of the MIPS datapath: instruction fetch, decode, execute, memory and writeback, one step per cycle.
- Shares a single memory port between instruction fetch and data access, with a memory-ready handshake.
- Replaces the single-cycle combinational controller for the multi-cycle core. The datapath instantiates it beside the IR, A/B, ALUOut and MDR registers.
- Adds an instruction-retired counter and an illegal-opcode flag for debug.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory handshake; the access completes in the cycle this is high.
- pc_en  out  1  PC register load = pcwrite | (pcwritecond & zero).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- irwrite  out  1  IR load.
- mdrwrite  out  1  MDR load.
- memtoreg  out  1  register write data: 0 = ALUOut, 1 = MDR.
- regdst  out  1  write register: 0 = rt, 1 = rd.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A input: 0 = PC, 1 = A.
- alusrcb  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
- aluop  out  2  00 = add, 01 = sub, 10 = funct field.
- pcsource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state, for debug.
- illegal_op  out  1  one-cycle pulse on an unknown opcode.
- instr_count  out  CNT_W  number of retired instructions.

Behaviour:
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
  - irwrite and pcwrite are asserted only when mem_ready=1; then go to DECODE.
  - Otherwise stay in FETCH with PC and IR held.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut).
  - RTYPE -> EXEC; LW/SW -> MEMADR; BEQ -> BRANCH; ADDI -> ADDIEX; J -> JUMP.
  - Any other opcode -> FETCH, with illegal_op=1 for this cycle; not counted as retired.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. LW -> MEMRD; SW -> MEMWR.
- MEMRD: memread=1, iord=1, mdrwrite=mem_ready. Stay until mem_ready, then go to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH.
- MEMWR: memwrite=1, iord=1. Stay until mem_ready, then go to FETCH.
  - memwrite stays high for every wait cycle; memory must treat it as level-sensitive.
- EXEC: alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01 -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
- JUMP: pcwrite=1, pcsource=10 -> FETCH.
- Output defaults: every output not listed for a state is 0.
- Outputs are decoded combinationally from the state register only (zero and mem_ready gate enables). Latency from state entry is 0.
- Cycle counts with mem_ready=1: RTYPE 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3.
- instr_count increments by 1 on the final cycle of each instruction:
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP;
  - MEMWR only when mem_ready=1.
  - Wraps modulo 2^CNT_W.
- Reset:
  - While rst=1, pc_en, irwrite, mdrwrite, regwrite, memwrite, memread and illegal_op are forced to 0, regardless of state.
  - At the next edge, state becomes FETCH and instr_count becomes 0.
  - Reset mid-instruction, including during a mem_ready wait, abandons the instruction with no partial write after the reset edge.
- Once reset is released, FETCH behaviour begins in that same cycle.
- A branch that is not taken still counts as retired.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the opcode constants;
  - the 4-bit state encodings (FETCH=0 … JUMP=11);
  - the alusrcb, aluop and pcsource encodings.
- One sub-module, mips_ctrl_outdec: a combinational decode from state, zero and mem_ready to the control outputs. The FSM next-state logic and the counter stay in the top module.

Test Plan:
- Reset: hold rst for 2 cycles, with the FSM mid-MEMRD beforehand -> state=0, instr_count=0, all write enables 0 during reset, memread=1 in the first cycle after release.
- R-type (opcode 000000), mem_ready=1 -> states FETCH, DECODE, EXEC, ALUWB; regwrite=1 and regdst=1 only in cycle 4; instr_count=1.
- LW with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles, mdrwrite asserted only in the 4th, MEMWB follows, 8 cycles total.
- BEQ with zero=1, then zero=0 -> pc_en=1 and 0 respectively in BRANCH; each takes 3 cycles; instr_count +2.
- SW then J -> memwrite=1 only in MEMWR; pcsource=10 with pc_en=1 in JUMP; instr_count +2.
- Opcode 111111 -> DECODE returns to FETCH, illegal_op pulses once, instr_count unchanged.
